// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared core package: trap FSM encoding, CSR addresses, mcause constants
package irq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARB      = 3'd1,
    ST_WAIT_RET = 3'd2,
    ST_ENTER    = 3'd3,
    ST_HANDLER  = 3'd4,
    ST_RETURN   = 3'd5
  } irq_state_t;

  localparam logic [11:0] CSR_MIE    = 12'h304;
  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  localparam logic [31:0] MCAUSE_IRQ_BIT      = 32'h8000_0000;
  localparam logic [1:0]  MTVEC_MODE_VECTORED = 2'b01;

  // Handler entry address: aligned base, plus the per-line offset in vectored mode.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic [31:0] offset);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == MTVEC_MODE_VECTORED) begin
      return base + offset;
    end
    return base;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - fixed-priority encoder, lowest set index wins
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N    = 6,
  parameter int ID_W = 3
) (
  input  logic [N-1:0]    i_eligible,
  output logic            o_valid,
  output logic [ID_W-1:0] o_id,
  output logic [N-1:0]    o_onehot
);

  logic [N-1:0] w_neg;

  assign o_valid  = |i_eligible;
  assign w_neg    = ~i_eligible + N'(1);
  assign o_onehot = i_eligible & w_neg;

  always_comb begin
    o_id = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_eligible[k]) begin
        o_id = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - machine external interrupt controller: pending capture, arbitration, trap entry/return
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          N_IRQ  = 6,
  parameter logic [31:0] RST_PC = 32'h0000_0000
) (
  input  logic             i_CLK,
  input  logic             i_RSTn,
  input  logic [N_IRQ-1:0] i_MEI,
  input  logic [N_IRQ-1:0] i_MIE,
  input  logic [31:0]      i_MTVEC,
  input  logic [31:0]      i_MEPC,
  input  logic [31:0]      i_PC,
  input  logic             i_RETIRE,
  input  logic             i_MRET,
  input  logic             i_REDIRECT_ACK,
  output logic             o_REDIRECT,
  output logic [31:0]      o_REDIRECT_PC,
  output logic             o_EPC_WE,
  output logic [31:0]      o_EPC,
  output logic [31:0]      o_MCAUSE,
  output logic             o_IN_TRAP
);

  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  irq_state_t       r_state;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_mei_q;
  logic [N_IRQ-1:0] r_onehot;
  logic [ID_W-1:0]  r_id;
  logic             r_redirect;
  logic [31:0]      r_redirect_pc;
  logic             r_epc_we;
  logic [31:0]      r_epc;
  logic [31:0]      r_mcause;
  logic             r_in_trap;

  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_eligible;
  logic [N_IRQ-1:0] w_clr;
  logic             w_win_valid;
  logic [ID_W-1:0]  w_win_id;
  logic [N_IRQ-1:0] w_win_onehot;
  logic [31:0]      w_mcause;
  logic [31:0]      w_vec_off;

  assign w_rise     = i_MEI & ~r_mei_q;
  assign w_eligible = r_pending & i_MIE;
  assign w_clr      = (r_state == ST_ARB) ? w_win_onehot : '0;
  assign w_mcause   = MCAUSE_IRQ_BIT | {{(32 - N_IRQ){1'b0}}, r_onehot};
  assign w_vec_off  = {{(30 - ID_W){1'b0}}, r_id, 2'b00};

  irq_prio_enc #(
    .N    (N_IRQ),
    .ID_W (ID_W)
  ) u_prio_enc (
    .i_eligible (w_eligible),
    .o_valid    (w_win_valid),
    .o_id       (w_win_id),
    .o_onehot   (w_win_onehot)
  );

  // A new edge in the same cycle as the ARB clear must survive, so set is applied last.
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_mei_q   <= '0;
      r_pending <= '0;
    end else begin
      r_mei_q   <= i_MEI;
      r_pending <= (r_pending & ~w_clr) | w_rise;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_state       <= ST_IDLE;
      r_id          <= '0;
      r_onehot      <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= RST_PC;
      r_epc_we      <= 1'b0;
      r_epc         <= '0;
      r_mcause      <= '0;
      r_in_trap     <= 1'b0;
    end else begin
      r_epc_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_state <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (w_win_valid) begin
            r_id     <= w_win_id;
            r_onehot <= w_win_onehot;
            r_state  <= ST_WAIT_RET;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT_RET: begin
          if (i_RETIRE) begin
            r_epc_we      <= 1'b1;
            r_epc         <= i_PC;
            r_mcause      <= w_mcause;
            r_redirect    <= 1'b1;
            r_redirect_pc <= trap_target(i_MTVEC, w_vec_off);
            r_state       <= ST_ENTER;
          end
        end
        ST_ENTER: begin
          if (i_REDIRECT_ACK) begin
            r_redirect <= 1'b0;
            r_in_trap  <= 1'b1;
            r_state    <= ST_HANDLER;
          end
        end
        ST_HANDLER: begin
          if (i_MRET) begin
            r_in_trap     <= 1'b0;
            r_redirect    <= 1'b1;
            r_redirect_pc <= i_MEPC;
            r_state       <= ST_RETURN;
          end
        end
        ST_RETURN: begin
          if (i_REDIRECT_ACK) begin
            r_redirect <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_redirect <= 1'b0;
          r_in_trap  <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_REDIRECT    = r_redirect;
  assign o_REDIRECT_PC = r_redirect_pc;
  assign o_EPC_WE      = r_epc_we;
  assign o_EPC         = r_epc;
  assign o_MCAUSE      = r_mcause;
  assign o_IN_TRAP     = r_in_trap;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;

  localparam logic [31:0] RST_PC = 32'hDEAD_BEE0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  mei, mie;
  logic [31:0] mtvec, mepc, pc;
  logic        retire, mret, ack;
  logic        redirect, epc_we, in_trap;
  logic [31:0] redirect_pc, epc, mcause;

  int errors = 0;
  int checks = 0;

  irq_ctrl #(.N_IRQ(6), .RST_PC(RST_PC)) dut (
    .i_CLK          (clk),
    .i_RSTn         (rst_n),
    .i_MEI          (mei),
    .i_MIE          (mie),
    .i_MTVEC        (mtvec),
    .i_MEPC         (mepc),
    .i_PC           (pc),
    .i_RETIRE       (retire),
    .i_MRET         (mret),
    .i_REDIRECT_ACK (ack),
    .o_REDIRECT     (redirect),
    .o_REDIRECT_PC  (redirect_pc),
    .o_EPC_WE       (epc_we),
    .o_EPC          (epc),
    .o_MCAUSE       (mcause),
    .o_IN_TRAP      (in_trap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_mei(input logic [5:0] m);
    mei = m;
    tick();
    mei = '0;
  endtask

  task automatic ack_once();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic wait_we(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (epc_we === 1'b1) seen = 1'b1;
    end
  endtask

  // Walk an entered trap through handler and return without inspecting it.
  task automatic service();
    ack_once();
    mret = 1'b1;
    tick();
    mret = 1'b0;
    ack_once();
  endtask

  task automatic test_reset();
    bit quiet;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b want 0", redirect); end
    checks++; if (redirect_pc !== RST_PC) begin errors++; $display("FAIL reset_redirect_pc: got %h want %h", redirect_pc, RST_PC); end
    checks++; if ({epc_we, in_trap} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {epc_we, in_trap}); end
    checks++; if ({epc, mcause} !== 64'h0) begin errors++; $display("FAIL reset_epc_mcause: got %h want 0", {epc, mcause}); end
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (4) begin tick(); if (redirect !== 1'b0 || epc_we !== 1'b0) quiet = 1'b0; end
    checks++; if (!quiet) begin errors++; $display("FAIL reset_idle_quiet: got activity want none"); end
  endtask

  task automatic test_direct();
    bit seen;
    mie = 6'h3F; mtvec = 32'h100; mepc = 32'h44; pc = 32'h40; retire = 1'b1;
    pulse_mei(6'b000100);
    wait_we(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL direct_epc_we: got %b want 1", seen); end
    checks++; if (epc !== 32'h40) begin errors++; $display("FAIL direct_epc: got %h want 00000040", epc); end
    checks++; if (mcause !== 32'h8000_0004) begin errors++; $display("FAIL direct_mcause: got %h want 80000004", mcause); end
    checks++; if ({redirect, redirect_pc} !== {1'b1, 32'h100}) begin errors++; $display("FAIL direct_redirect: got %b %h want 1 00000100", redirect, redirect_pc); end
    checks++; if (in_trap !== 1'b0) begin errors++; $display("FAIL direct_in_trap_early: got %b want 0", in_trap); end
    retire = 1'b0;
    tick();
    checks++; if ({epc_we, redirect} !== 2'b01) begin errors++; $display("FAIL direct_we_pulse: got %b want 01", {epc_we, redirect}); end
    ack_once();
    checks++; if ({redirect, in_trap} !== 2'b01) begin errors++; $display("FAIL direct_handler: got %b want 01", {redirect, in_trap}); end
    mret = 1'b1; tick(); mret = 1'b0;
    checks++; if ({redirect, redirect_pc, in_trap} !== {1'b1, 32'h44, 1'b0}) begin errors++; $display("FAIL direct_return: got %b %h %b want 1 00000044 0", redirect, redirect_pc, in_trap); end
    ack_once();
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL direct_return_ack: got %b want 0", redirect); end
    repeat (5) tick();
    checks++; if ({redirect, epc_we} !== 2'b00) begin errors++; $display("FAIL direct_no_retrap: got %b want 00", {redirect, epc_we}); end
  endtask

  task automatic test_priority();
    bit seen;
    mie = 6'h3F; mtvec = 32'h201; pc = 32'h300; retire = 1'b1;
    pulse_mei(6'b010010);
    wait_we(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL prio_first_we: got %b want 1", seen); end
    checks++; if (mcause !== 32'h8000_0002) begin errors++; $display("FAIL prio_first_mcause: got %h want 80000002", mcause); end
    checks++; if (redirect_pc !== 32'h204) begin errors++; $display("FAIL prio_first_pc: got %h want 00000204", redirect_pc); end
    checks++; if (epc !== 32'h300) begin errors++; $display("FAIL prio_first_epc: got %h want 00000300", epc); end
    service();
    wait_we(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL prio_second_we: got %b want 1", seen); end
    checks++; if (mcause !== 32'h8000_0010) begin errors++; $display("FAIL prio_second_mcause: got %h want 80000010", mcause); end
    checks++; if (redirect_pc !== 32'h210) begin errors++; $display("FAIL prio_second_pc: got %h want 00000210", redirect_pc); end
    service();
  endtask

  task automatic test_masked();
    bit seen, quiet;
    mie = 6'h37; mtvec = 32'h100; retire = 1'b1;
    pulse_mei(6'b001000);
    quiet = 1'b1;
    repeat (10) begin tick(); if (redirect !== 1'b0 || epc_we !== 1'b0) quiet = 1'b0; end
    checks++; if (!quiet) begin errors++; $display("FAIL masked_no_trap: got activity want none"); end
    mie = 6'h3F;
    wait_we(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL masked_late_we: got %b want 1", seen); end
    checks++; if (mcause !== 32'h8000_0008) begin errors++; $display("FAIL masked_mcause: got %h want 80000008", mcause); end
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL masked_pc: got %h want 00000100", redirect_pc); end
    service();
  endtask

  task automatic test_handler_edge();
    bit seen, quiet;
    mie = 6'h3F; mtvec = 32'h100; mepc = 32'h80; retire = 1'b1;
    pulse_mei(6'b100000);
    wait_we(10, seen);
    checks++; if (mcause !== 32'h8000_0020) begin errors++; $display("FAIL hedge_first_mcause: got %h want 80000020", mcause); end
    ack_once();
    pulse_mei(6'b000001);
    quiet = 1'b1;
    repeat (5) begin tick(); if (redirect !== 1'b0 || in_trap !== 1'b1 || epc_we !== 1'b0) quiet = 1'b0; end
    checks++; if (!quiet) begin errors++; $display("FAIL hedge_no_nesting: got activity want none"); end
    mret = 1'b1; tick(); mret = 1'b0;
    checks++; if ({redirect, redirect_pc} !== {1'b1, 32'h80}) begin errors++; $display("FAIL hedge_return_pc: got %b %h want 1 00000080", redirect, redirect_pc); end
    ack_once();
    wait_we(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL hedge_second_we: got %b want 1", seen); end
    checks++; if ({mcause, redirect_pc} !== {32'h8000_0001, 32'h100}) begin errors++; $display("FAIL hedge_second_entry: got %h %h want 80000001 00000100", mcause, redirect_pc); end
    service();
  endtask

  task automatic test_ack_stall();
    bit seen, stable;
    mie = 6'h3F; mtvec = 32'h201; mepc = 32'h500; retire = 1'b1;
    ack = 1'b1; mret = 1'b1;
    repeat (3) tick();
    ack = 1'b0; mret = 1'b0;
    checks++; if ({redirect, in_trap} !== 2'b00) begin errors++; $display("FAIL stall_stray_ack_mret: got %b want 00", {redirect, in_trap}); end
    pulse_mei(6'b000010);
    wait_we(10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL stall_we: got %b want 1", seen); end
    mret = 1'b1;
    stable = 1'b1;
    repeat (5) begin tick(); if (redirect !== 1'b1 || redirect_pc !== 32'h204 || in_trap !== 1'b0) stable = 1'b0; end
    mret = 1'b0;
    checks++; if (!stable) begin errors++; $display("FAIL stall_hold: got %b %h want 1 00000204", redirect, redirect_pc); end
    ack_once();
    checks++; if ({redirect, in_trap} !== 2'b01) begin errors++; $display("FAIL stall_ack_handler: got %b want 01", {redirect, in_trap}); end
    mret = 1'b1; tick(); mret = 1'b0;
    ack_once();
  endtask

  task automatic test_set_wins();
    bit seen, quiet;
    mie = 6'h3F; mtvec = 32'h100; retire = 1'b1;
    mei = 6'b000100; tick();
    mei = 6'b000000; tick();
    mei = 6'b000100; tick();
    mei = 6'b000000;
    wait_we(10, seen);
    checks++; if ({seen, mcause} !== {1'b1, 32'h8000_0004}) begin errors++; $display("FAIL setwins_first: got %b %h want 1 80000004", seen, mcause); end
    service();
    wait_we(10, seen);
    checks++; if ({seen, mcause} !== {1'b1, 32'h8000_0004}) begin errors++; $display("FAIL setwins_second: got %b %h want 1 80000004", seen, mcause); end
    service();
    quiet = 1'b1;
    repeat (8) begin tick(); if (redirect !== 1'b0 || epc_we !== 1'b0) quiet = 1'b0; end
    checks++; if (!quiet) begin errors++; $display("FAIL setwins_no_third: got activity want none"); end
  endtask

  task automatic test_no_count();
    bit seen, quiet;
    mie = 6'h3B; mtvec = 32'h100; retire = 1'b1;
    pulse_mei(6'b000100); tick(); tick();
    pulse_mei(6'b000100); tick(); tick();
    mie = 6'h3F;
    wait_we(10, seen);
    checks++; if ({seen, mcause} !== {1'b1, 32'h8000_0004}) begin errors++; $display("FAIL nocount_first: got %b %h want 1 80000004", seen, mcause); end
    service();
    quiet = 1'b1;
    repeat (10) begin tick(); if (redirect !== 1'b0 || epc_we !== 1'b0) quiet = 1'b0; end
    checks++; if (!quiet) begin errors++; $display("FAIL nocount_single: got activity want none"); end
  endtask

  task automatic test_reset_mid();
    bit seen, quiet;
    mie = 6'h2F; mtvec = 32'h100; retire = 1'b1;
    pulse_mei(6'b010000);
    pulse_mei(6'b000001);
    wait_we(10, seen);
    checks++; if ({seen, redirect} !== 2'b11) begin errors++; $display("FAIL rstmid_enter: got %b want 11", {seen, redirect}); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({redirect, redirect_pc} !== {1'b0, RST_PC}) begin errors++; $display("FAIL rstmid_async_redirect: got %b %h want 0 %h", redirect, redirect_pc, RST_PC); end
    checks++; if ({epc_we, in_trap, epc, mcause} !== 66'h0) begin errors++; $display("FAIL rstmid_async_csr: got %b %b %h %h want zeros", epc_we, in_trap, epc, mcause); end
    tick(); tick();
    rst_n = 1'b1;
    mie = 6'h3F;
    quiet = 1'b1;
    repeat (10) begin tick(); if (redirect !== 1'b0 || epc_we !== 1'b0) quiet = 1'b0; end
    checks++; if (!quiet) begin errors++; $display("FAIL rstmid_pending_cleared: got activity want none"); end
    pulse_mei(6'b001000);
    wait_we(10, seen);
    checks++; if ({seen, mcause} !== {1'b1, 32'h8000_0008}) begin errors++; $display("FAIL rstmid_after_release: got %b %h want 1 80000008", seen, mcause); end
    service();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; mei = '0; mie = '0; mtvec = '0; mepc = '0; pc = '0;
    retire = 1'b0; mret = 1'b0; ack = 1'b0;
    test_reset();
    test_direct();
    test_priority();
    test_masked();
    test_handler_edge();
    test_ack_stall();
    test_set_wins();
    test_no_count();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter N_IRQ, default 6, meaning number of machine external interrupt lines.
REQ-002 SHALL have parameter RST_PC, default 32'h0000_0000, meaning reset value of o_REDIRECT_PC.
REQ-003 SHALL have port i_CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_RSTn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_MEI  input  N_IRQ  level interrupt requests.
REQ-006 SHALL have port i_MIE  input  N_IRQ  per-line enable mask, driven from the mie CSR.
REQ-007 SHALL have port i_MTVEC  input  32  trap vector base; [1:0]=01 selects vectored mode.
REQ-008 SHALL have port i_MEPC  input  32  saved return PC, driven from the mepc CSR.
REQ-009 SHALL have port i_PC  input  32  PC of the instruction retiring this cycle.
REQ-010 SHALL have port i_RETIRE  input  1  instruction boundary strobe.
REQ-011 SHALL have port i_MRET  input  1  MRET retiring this cycle.
REQ-012 SHALL have port i_REDIRECT_ACK  input  1  fetch accepted the redirect.
REQ-013 SHALL have port o_REDIRECT  output  1  fetch redirect request.
REQ-014 SHALL have port o_REDIRECT_PC  output  32  redirect target.
REQ-015 SHALL have port o_EPC_WE  output  1  one-cycle strobe writing o_EPC/o_MCAUSE into the CSR file.
REQ-016 SHALL have port o_EPC  output  32  PC to save in mepc.
REQ-017 SHALL have port o_MCAUSE  output  32  cause to save in mcause.
REQ-018 SHALL have port o_IN_TRAP  output  1  high while a handler is executing.

Function
REQ-019 SHALL hold per-line pending bits; pending[k] sets on the cycle after a rising edge of i_MEI[k], independent of i_MIE.
REQ-020 SHALL treat line k as eligible only when pending[k] & i_MIE[k]; a masked pending bit is retained.
REQ-021 SHALL pick the lowest eligible index (line 0 highest priority).
REQ-022 SHALL implement FSM IDLE -> ARB -> WAIT_RET -> ENTER -> HANDLER -> RETURN -> IDLE.
REQ-023 IDLE: any eligible line -> ARB next cycle.
REQ-024 ARB: latch winner id, clear pending[id] in the same edge, -> WAIT_RET; if nothing is eligible (mask dropped) -> IDLE.
REQ-025 WAIT_RET: on i_RETIRE, pulse o_EPC_WE for exactly that cycle with o_EPC=i_PC and o_MCAUSE={1'b1,(31-N_IRQ) zeros,onehot(id)}, -> ENTER.
REQ-026 ENTER: assert o_REDIRECT with o_REDIRECT_PC={i_MTVEC[31:2],2'b00} (direct) or that +4*id (vectored, 32-bit wrap); hold until i_REDIRECT_ACK, then -> HANDLER.
REQ-027 HANDLER: o_IN_TRAP=1; new edges still set pending but no arbitration; i_MRET -> RETURN.
REQ-028 RETURN: o_REDIRECT=1, o_REDIRECT_PC=i_MEPC until i_REDIRECT_ACK, then -> IDLE; a still-eligible line re-enters ARB next cycle.
REQ-029 i_MRET outside HANDLER SHALL be ignored; i_REDIRECT_ACK without o_REDIRECT SHALL be ignored.
REQ-030 Edge on a line whose pending bit is already set SHALL leave one pending request (no counting).
REQ-031 Edge on line id in the same cycle ARB clears it SHALL leave pending[id]=1 (set wins).

Reset
REQ-032 Reset SHALL force IDLE, pending=0, edge history=0, o_REDIRECT=0, o_REDIRECT_PC=RST_PC, o_EPC_WE=0, o_EPC=0, o_MCAUSE=0, o_IN_TRAP=0, immediately and regardless of state, including mid-redirect.

Structure
REQ-033 State encoding, CSR addresses (MIE, MTVEC, MEPC, MCAUSE) and the mcause interrupt-bit constant SHALL live in the shared core package.
REQ-034 The priority encoder SHALL be sub-module irq_prio_enc (eligible vector in, valid + id + onehot out).

Verification
REQ-035 Line 2 edge, i_MIE=6'h3F, MTVEC=0x100 direct, retire at PC 0x40 -> EPC_WE pulse, EPC=0x40, MCAUSE=0x8000_0004, redirect 0x100.
REQ-036 Lines 1 and 4 rise same cycle, MTVEC=0x201 vectored -> line 1 first, redirect 0x204; after MRET/ack, line 4 taken, redirect 0x210.
REQ-037 Line 3 edge with i_MIE[3]=0 -> no trap; set i_MIE[3]=1 10 cycles later -> trap taken, MCAUSE=0x8000_0008.
REQ-038 Line 0 edge during HANDLER -> no redirect until MRET; RETURN redirect to i_MEPC=0x80, then line 0 trap entry.
REQ-039 i_REDIRECT_ACK held low 5 cycles in ENTER -> o_REDIRECT and PC stable all 5 cycles; ack -> HANDLER next cycle.
REQ-040 i_RSTn low during ENTER -> o_REDIRECT=0 asynchronously, pending cleared, IDLE after release.
